// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: the round-constant table, the Nk/Nr
// helpers, the emitter state encoding and the RotWord helper.
package aes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rk_state_t;

    localparam logic [7:0] RCON_TBL [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/256 key expansion streaming one round key per beat.
// Optional round-key cache behind the AES_KEY_CACHE_EN macro.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [3:0]          rk_round,
    output logic [127:0]        rk_data,
    output logic                done
`ifdef AES_KEY_CACHE_EN
    ,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_data,
    output logic                rd_hit
`endif
);

    localparam int         NK      = nk_of(KEY_BITS);
    localparam logic [3:0] NR_L    = 4'(nr_of(KEY_BITS));
    localparam logic [3:0] IDX_MAX = (KEY_BITS == 256) ? 4'd6 : 4'd9;

    if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_key_expand: KEY_BITS must be 128 or 256, got %0d", KEY_BITS);
    end

    rk_state_t           state_q, state_d;
    logic [KEY_BITS-1:0] win_q, win_d, win_shift;
    logic [3:0]          round_q, round_d, idx_q, idx_d;
    logic                done_q, done_d;
    logic                start_acc, beat, last_beat, rcon_step;
    logic [31:0]         prev, sub_in, sub_out, t;
    logic [31:0]         head [4];
    logic [31:0]         nw   [4];

    assign start_acc = (state_q == IDLE) && start;
    assign beat      = (state_q == EMIT) && rk_ready;
    assign last_beat = beat && (round_q == NR_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EMIT;
            EMIT:    if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rk_valid = 1'b0;
        busy     = 1'b0;
        if (state_q == EMIT) begin
            rk_valid = 1'b1;
            busy     = 1'b1;
        end
    end

    // AES-256 alternates Rcon steps (even rounds) with plain SubWord steps.
    assign rcon_step = (NK == 4) || !round_q[0];
    assign prev      = win_q[31:0];
    assign sub_in    = rcon_step ? rot_word(prev) : prev;
    assign t         = rcon_step ? (sub_out ^ {RCON_TBL[idx_q], 24'h0}) : sub_out;

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        aes_sbox u_sbox (
            .a_i (sub_in[8*gi +: 8]),
            .y_o (sub_out[8*gi +: 8])
        );
        assign head[gi] = win_q[KEY_BITS-1-32*gi -: 32];
        if (gi == 0) begin : g_first
            assign nw[gi] = head[gi] ^ t;
        end else begin : g_chain
            assign nw[gi] = head[gi] ^ nw[gi-1];
        end
    end

    if (KEY_BITS == 128) begin : g_shift128
        assign win_shift = {nw[0], nw[1], nw[2], nw[3]};
    end else begin : g_shift_wide
        assign win_shift = {win_q[KEY_BITS-129:0], nw[0], nw[1], nw[2], nw[3]};
    end

    always_comb begin
        win_d   = win_q;
        round_d = round_q;
        idx_d   = idx_q;
        done_d  = last_beat;
        if (start_acc) begin
            win_d   = key_in;
            round_d = 4'd0;
            idx_d   = 4'd0;
        end else if (beat && !last_beat) begin
            win_d   = win_shift;
            round_d = round_q + 4'd1;
            if (rcon_step && idx_q != IDX_MAX) idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '0;
            round_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            win_q   <= win_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign rk_round = round_q;
    assign rk_data  = win_q[KEY_BITS-1 -: 128];
    assign done     = done_q;

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_q [15];
    logic         cache_ok_q, cache_ok_d;
    logic [127:0] rd_data_q, rd_data_d;
    logic         rd_hit_q, rd_hit_d;

    // Valid only between a completed stream and the next start.
    always_comb begin
        cache_ok_d = cache_ok_q;
        if (start_acc)      cache_ok_d = 1'b0;
        else if (last_beat) cache_ok_d = 1'b1;
        rd_hit_d  = (state_q == IDLE) && cache_ok_q && (rd_round <= NR_L);
        rd_data_d = rd_hit_d ? cache_q[rd_round] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) cache_q[i] <= '0;
            cache_ok_q <= 1'b0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            if (beat) cache_q[round_q] <= rk_data;
            cache_ok_q <= cache_ok_d;
            rd_data_q  <= rd_data_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand (AES-128 and AES-256 instances)
// against a FIPS-197 key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_s = 1'b0;
    logic         sel = 1'b0;
    logic         ready_s = 1'b0;
    logic [255:0] key_s = '0;
    logic         start128, start256;
    logic         busy128, valid128, done128, busy256, valid256, done256;
    logic [3:0]   round128, round256;
    logic [127:0] data128, data256;
    logic         cur_valid, cur_busy, cur_done;
    logic [3:0]   cur_round;
    logic [127:0] cur_data;
`ifdef AES_KEY_CACHE_EN
    logic [3:0]   rd_round = 4'd0;
    logic [127:0] rd_data, rd_data256;
    logic         rd_hit, rd_hit256;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0]   sb [256];
    logic [31:0]  w [60];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];

    localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K3 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    always #5 clk = ~clk;

    assign start128  = start_s & ~sel;
    assign start256  = start_s & sel;
    assign cur_valid = sel ? valid256 : valid128;
    assign cur_busy  = sel ? busy256  : busy128;
    assign cur_done  = sel ? done256  : done128;
    assign cur_round = sel ? round256 : round128;
    assign cur_data  = sel ? data256  : data128;

    aes_key_expand #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .key_in(key_s[255:128]),
        .busy(busy128), .rk_valid(valid128), .rk_ready(ready_s),
        .rk_round(round128), .rk_data(data128), .done(done128)
`ifdef AES_KEY_CACHE_EN
        , .rd_round(rd_round), .rd_data(rd_data), .rd_hit(rd_hit)
`endif
    );

    aes_key_expand #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .start(start256), .key_in(key_s),
        .busy(busy256), .rk_valid(valid256), .rk_ready(ready_s),
        .rk_round(round256), .rk_data(data256), .done(done256)
`ifdef AES_KEY_CACHE_EN
        , .rd_round(rd_round), .rd_data(rd_data256), .rd_hit(rd_hit256)
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            if (v == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Key is left-aligned in 256 bits; nk = 4 or 8.
    task automatic build_schedule(input logic [255:0] key, input int nk);
        logic [7:0]  rc;
        logic [31:0] tmp;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic run_stream(input logic [255:0] key, input bit is256, input bit bp, output int cyc);
        int nr, r;
        bit stalled;
        logic [127:0] prev_data;
        nr = is256 ? 14 : 10;
        build_schedule(key, is256 ? 8 : 4);
        @(posedge clk); #1;
        sel = is256; key_s = key; start_s = 1'b1; ready_s = 1'b0;
        @(posedge clk); #1;
        start_s = 1'b0; cyc = 0; r = 0; stalled = 1'b0; prev_data = '0;
        while (r <= nr && cyc < 400) begin
            ready_s = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            checks++;
            if (cur_valid !== 1'b1 || cur_round !== r[3:0] || cur_data !== exp_rk[r]) begin
                errors++;
                $display("FAIL beat: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                         cur_valid, cur_round, cur_data, r, exp_rk[r]);
            end
            checks++;
            if (cur_busy !== 1'b1 || cur_done !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_stream: busy=%b done=%b, required busy=1 done=0", cur_busy, cur_done);
            end
            if (stalled) begin
                checks++;
                if (cur_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: data=%h, required %h", cur_data, prev_data);
                end
            end
            got_rk[r] = cur_data;
            prev_data = cur_data;
            stalled   = !ready_s;
            if (ready_s) r++;
            @(posedge clk); #1;
            cyc++;
        end
        ready_s = 1'b0;
        checks++;
        if (r <= nr) begin
            errors++;
            $display("FAIL stream_timeout: reached round %0d, required %0d", r, nr + 1);
        end
        checks++;
        if (cur_done !== 1'b1 || cur_valid !== 1'b0 || cur_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b, required 1 0 0", cur_done, cur_valid, cur_busy);
        end
        $display("stream aes%0d key=%h bp=%0d cycles=%0d", is256 ? 256 : 128, key, bp, cyc);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid128, busy128, done128, round128, data128} !== '0 ||
            {valid256, busy256, done256, round256, data256} !== '0) begin
            errors++;
            $display("FAIL reset_state: aes128 v=%b b=%b d=%b r=%0d data=%h, required all 0",
                     valid128, busy128, done128, round128, data128);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_fips128();
        int cyc;
        run_stream(K1, 1'b0, 1'b0, cyc);
        checks++;
        if (got_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++; $display("FAIL fips128_r0: got %h, required key", got_rk[0]);
        end
        checks++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL fips128_r1: got %h, required a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        checks++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL fips128_r10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        checks++;
        if (cyc !== 11) begin
            errors++; $display("FAIL fips128_latency: done after %0d cycles, required 11", cyc);
        end
    endtask

    task automatic test_fips256();
        int cyc;
        run_stream(K2, 1'b1, 1'b0, cyc);
        checks++;
        if (got_rk[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin
            errors++; $display("FAIL fips256_r0: got %h, required 603deb1015ca71be2b73aef0857d7781", got_rk[0]);
        end
        checks++;
        if (got_rk[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin
            errors++; $display("FAIL fips256_r1: got %h, required 1f352c073b6108d72d9810a30914dff4", got_rk[1]);
        end
        checks++;
        if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++; $display("FAIL fips256_r14: got %h, required fe4890d1e6188d0b046df344706c631e", got_rk[14]);
        end
        checks++;
        if (cyc !== 15) begin
            errors++; $display("FAIL fips256_latency: done after %0d cycles, required 15", cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        run_stream(K1, 1'b0, 1'b1, cyc);
        checks++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL bp_r10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_random_keys();
        int cyc;
        logic [255:0] key;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom;
            run_stream(key, 1'(it % 2), 1'(it / 2), cyc);
        end
    endtask

    task automatic test_start_ignored();
        int r, cyc;
        build_schedule(K1, 4);
        @(posedge clk); #1;
        sel = 1'b0; key_s = K1; start_s = 1'b1; ready_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0; r = 0; cyc = 0;
        while (r <= 10 && cyc < 100) begin
            checks++;
            if (cur_valid !== 1'b1 || cur_round !== r[3:0] || cur_data !== exp_rk[r]) begin
                errors++;
                $display("FAIL ignored_start_beat: round=%0d data=%h, required round=%0d data=%h",
                         cur_round, cur_data, r, exp_rk[r]);
            end
            if (r == 5) begin key_s = K3; start_s = 1'b1; end
            else start_s = 1'b0;
            r++;
            @(posedge clk); #1;
            cyc++;
        end
        start_s = 1'b0;
        checks++;
        if (cur_done !== 1'b1 || cur_valid !== 1'b0) begin
            errors++; $display("FAIL ignored_start_done: done=%b valid=%b, required 1 0", cur_done, cur_valid);
        end
        key_s = K3; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        checks++;
        if (cur_valid !== 1'b1 || cur_round !== 4'd0 || cur_data !== K3[255:128]) begin
            errors++;
            $display("FAIL start_in_done: valid=%b round=%0d data=%h, required 1 0 %h",
                     cur_valid, cur_round, cur_data, K3[255:128]);
        end
        cyc = 0;
        while (!cur_done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cur_done !== 1'b1) begin
            errors++; $display("FAIL chained_done: done=%b after %0d cycles, required 1", cur_done, cyc);
        end
        $display("start-ignore stream done, chained stream drained in %0d cycles", cyc);
    endtask

    task automatic test_reset_midstream();
        int cyc;
        build_schedule(K1, 4);
        @(posedge clk); #1;
        sel = 1'b0; key_s = K1; start_s = 1'b1; ready_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cur_round !== 4'd3 || cur_data !== exp_rk[3]) begin
            errors++; $display("FAIL pre_reset_r3: round=%0d data=%h, required 3 %h", cur_round, cur_data, exp_rk[3]);
        end
        ready_s = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({cur_valid, cur_busy, cur_done, cur_round, cur_data} !== '0) begin
            errors++;
            $display("FAIL midstream_reset: valid=%b busy=%b done=%b round=%0d data=%h, required all 0",
                     cur_valid, cur_busy, cur_done, cur_round, cur_data);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cur_done !== 1'b0 || cur_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: done=%b valid=%b, required 0 0", cur_done, cur_valid);
        end
        $display("reset applied at round 3");
        run_stream(K3, 1'b0, 1'b0, cyc);
    endtask

`ifdef AES_KEY_CACHE_EN
    task automatic test_cache();
        int cyc, rr;
        run_stream(K1, 1'b0, 1'b0, cyc);
        rd_round = 4'd10;
        @(posedge clk); #1;
        checks++;
        if (rd_hit !== 1'b1 || rd_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL cache_r10: hit=%b data=%h, required 1 d014f9a8c9ee2589e13f0cc8b6630ca6", rd_hit, rd_data);
        end
        rd_round = 4'd11;
        @(posedge clk); #1;
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== '0) begin
            errors++; $display("FAIL cache_r11: hit=%b data=%h, required 0 0", rd_hit, rd_data);
        end
        for (int k = 0; k < 6; k++) begin
            rr = $urandom_range(0, 10);
            rd_round = 4'(rr);
            @(posedge clk); #1;
            checks++;
            if (rd_hit !== 1'b1 || rd_data !== exp_rk[rr]) begin
                errors++; $display("FAIL cache_rand: round=%0d hit=%b data=%h, required 1 %h", rr, rd_hit, rd_data, exp_rk[rr]);
            end
        end
        $display("cache reads checked");
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_fips128();
`ifdef AES_KEY_CACHE_EN
        test_cache();
`endif
        test_fips256();
        test_backpressure();
        test_random_keys();
        test_start_ignored();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
